freq_gen_nco: RTL
=================

# freq_gen_nco

Programmable square-wave generator: the transmit-side counterpart of the frequency meter. It takes a target frequency in Hz and converts it to an NCO tuning word with a sequential restoring divider. It then drives a phase accumulator on `sys_clk`, so `clk_out` toggles at the requested rate. It provides the stimulus source for the frequency measurement path and is loaded over a valid/ready handshake.

## Interface
- `SYS_CLK_FREQ`, default 50_000_000: `sys_clk` frequency in Hz.
- `ACC_W`, default 32: phase accumulator and tuning word width.
- `FREQ_W`, default 34: width of the frequency request, in Hz.

Ports:
- `sys_clk`  in  1: system clock, the only clock.
- `sys_rst`  in  1: reset, asynchronous, active-high.
- `freq_set`  in  FREQ_W: requested output frequency in Hz.
- `set_valid`  in  1: request strobe; accepted when `set_valid && set_ready`.
- `set_ready`  out  1: high when no division is in progress.
- `clk_out`  out  1: generated square wave, registered.
- `tune_word`  out  ACC_W: active tuning word.
- `busy`  out  1: division in progress; always equals `!set_ready`.
- `err`  out  1: last accepted request was out of range.

## Operation
- State machine with three states: IDLE (no output), CALC (dividing), RUN (generating).
- Accept at edge T, when `set_valid && set_ready`. The request is classified as follows:
  - **`freq_set == 0`:** go to IDLE. Clear `acc`, set `tune_word` = 0, set `err` = 0.
  - **`freq_set > SYS_CLK_FREQ/2`:** set `err` = 1. State, `acc` and `tune_word` are unchanged. No CALC is entered.
  - **Otherwise:** set `err` = 0 and go to CALC. Load `rem` = `freq_set`, `q` = 0 and the iteration counter = 0. Return state is recorded (IDLE or RUN).
- CALC performs one iteration per cycle:
  - `rem` = `rem << 1`.
  - If `rem >= SYS_CLK_FREQ`, then `rem` -= `SYS_CLK_FREQ` and the shifted-in `q` bit is 1; otherwise the bit is 0.
- After ACC_W iterations, `q` = floor(`freq_set` × 2^ACC_W / `SYS_CLK_FREQ`).
- Width rules:
  - `rem` is FREQ_W+1 bits wide.
  - The quotient is at most 2^(ACC_W-1), because the request is at most f/2, so it never overflows.
- Load cycle: `tune_word` <= `q` and state goes to RUN.
- Accumulator: in RUN, and in CALC when the return state is RUN, `acc` <= `acc` + `tune_word` every cycle, wrapping modulo 2^ACC_W.
  - A retune is phase-continuous: `acc` is not cleared when a new word loads.
- `clk_out` <= `acc[ACC_W-1]`, registered. It is 0 in IDLE.
- `set_valid` while busy is ignored. There is no queueing; the requester must hold `set_valid` until it sees ready.

## Timing
- Reset values: `clk_out` = 0, `tune_word` = 0, `err` = 0, `busy` = 0, `set_ready` = 1, state IDLE, `acc` = 0.
- Reset asserted mid-CALC aborts the division immediately and gives the reset values above.
- Accept edge T: `busy` is high from T+1.
  - The iterations occur on edges T+1 through T+ACC_W.
  - The load happens on edge T+ACC_W+1, when `tune_word` updates and `busy` falls.
  - Request-to-word latency is ACC_W+1 cycles (33 by default).
- The first accumulation with the new word occurs on edge T+ACC_W+2. `clk_out` reflects it one edge later.
- Zero request: `acc` is cleared at edge T, and `clk_out` = 0 from T+1.
- Out-of-range request: `err` is set at T+1. `set_ready` stays high, and the next request is accepted on the following cycle.
- `clk_out` period is 2^ACC_W / `tune_word` cycles on average, with one cycle of jitter when non-integer.

## Configuration
- `FREQ_GEN_NCO_ROUND_EN`: when defined, CALC runs ACC_W+1 iterations, and the load stores (`q` + 1) >> 1, i.e. round-half-up. Latency becomes ACC_W+2 cycles.
- When not defined, the result is floor, with latency ACC_W+1.
- Range check and all other behaviour are identical in both builds.

## Test plan
- **Reset:** with `sys_rst` high, then released → `clk_out` = 0, `tune_word` = 0, `err` = 0, `busy` = 0, `set_ready` = 1, and `clk_out` is static for 100 cycles.
- **Exact divide:** `freq_set` = 12_500_000 from IDLE → `busy` is high for 33 cycles, then `tune_word` = 0x4000_0000. `clk_out` has period 4 cycles and 50% duty; a 1.5 s loopback into the meter reads 12_500_000.
- **Rounding:** `freq_set` = 1 → `tune_word` = 85 without `FREQ_GEN_NCO_ROUND_EN`, and 86 with it (latency 34).
- **Range:**
  - `freq_set` = 25_000_001 while running at 1_000_000 → `err` = 1 at T+1, and `tune_word` stays 85_899_345.
  - `freq_set` = 25_000_000 → `tune_word` = 0x8000_0000 and `err` = 0.
- **Stop and handshake:** in RUN, set `freq_set` = 0 → `clk_out` = 0 from T+1. Pulse `set_valid` during CALC with a different value → ignored, and the original word loads.
- **Reset mid-CALC:** assert `sys_rst` at T+10 → all outputs return to reset values. After release, a new request of 1_000_000 loads `tune_word` = 85_899_345 (floor build).

Source files
------------

// File: rtl/freq_gen_nco.sv
// Programmable square-wave NCO: converts a Hz request into a tuning word with a
// restoring divider, then drives a phase accumulator. Option: FREQ_GEN_NCO_ROUND_EN.
module freq_gen_nco #(
  parameter int unsigned SYS_CLK_FREQ = 50_000_000,
  parameter int unsigned ACC_W        = 32,
  parameter int unsigned FREQ_W       = 34
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [FREQ_W-1:0] freq_set,
  input  logic              set_valid,
  output logic              set_ready,
  output logic              clk_out,
  output logic [ACC_W-1:0]  tune_word,
  output logic              busy,
  output logic              err
);

`ifdef FREQ_GEN_NCO_ROUND_EN
  localparam int unsigned ITER = ACC_W + 1;
`else
  localparam int unsigned ITER = ACC_W;
`endif
  localparam int unsigned Q_W   = ITER;
  localparam int unsigned REM_W = FREQ_W + 1;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  localparam logic [REM_W-1:0]  DIVISOR  = REM_W'(SYS_CLK_FREQ);
  localparam logic [FREQ_W-1:0] MAX_FREQ = FREQ_W'(SYS_CLK_FREQ / 2);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ITER);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_RUN
  } state_e;

  state_e             state_q, state_d;
  logic               ret_run_q, ret_run_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [Q_W-1:0]     quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   tune_q, tune_d;
  logic               clk_q, clk_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               accept;
  logic [REM_W-1:0]   rem_shift;
  logic [ACC_W-1:0]   load_word;

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      ret_run_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      tune_q    <= '0;
      clk_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_run_q <= ret_run_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      tune_q    <= tune_d;
      clk_q     <= clk_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // Next-state: request classification, divider iterations and accumulator
  always_comb begin
    state_d   = state_q;
    ret_run_d = ret_run_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    tune_d    = tune_q;
    err_d     = err_q;
    clk_d     = (state_q == ST_IDLE) ? 1'b0 : acc_q[ACC_W-1];
    accept    = set_valid && !busy_q;
    rem_shift = rem_q << 1;
`ifdef FREQ_GEN_NCO_ROUND_EN
    load_word = ACC_W'(((ACC_W + 2)'(quo_q) + (ACC_W + 2)'(1)) >> 1);
`else
    load_word = ACC_W'(quo_q);
`endif

    // Keep the phase running while a retune is being computed
    if (state_q == ST_RUN || (state_q == ST_CALC && ret_run_q)) begin
      acc_d = acc_q + tune_q;
    end

    case (state_q)
      ST_CALC: begin
        if (cnt_q == LAST_CNT) begin
          tune_d  = load_word;
          state_d = ST_RUN;
        end else begin
          if (rem_shift >= DIVISOR) begin
            rem_d = rem_shift - DIVISOR;
            quo_d = {quo_q[Q_W-2:0], 1'b1};
          end else begin
            rem_d = rem_shift;
            quo_d = {quo_q[Q_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (accept) begin
          if (freq_set == '0) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            tune_d  = '0;
            err_d   = 1'b0;
            clk_d   = 1'b0;
          end else if (freq_set > MAX_FREQ) begin
            err_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            ret_run_d = (state_q == ST_RUN);
            state_d   = ST_CALC;
            rem_d     = {1'b0, freq_set};
            quo_d     = '0;
            cnt_d     = '0;
          end
        end
      end
    endcase

    busy_d = (state_d == ST_CALC);
  end

  assign set_ready = !busy_q;
  assign busy      = busy_q;
  assign clk_out   = clk_q;
  assign tune_word = tune_q;
  assign err       = err_q;

endmodule
